// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 engine.
// RC4_ASCII_CHECK_EN selects the optional plaintext checker in rc4_engine.
package rc4_pkg;

    localparam int unsigned S_DEPTH  = 256;
    localparam logic [7:0]  ASCII_LO = 8'h61;
    localparam logic [7:0]  ASCII_HI = 8'h7A;
    localparam logic [7:0]  ASCII_SP = 8'h20;

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StKsaA,
        StKsaB,
        StKsaC,
        StKsaD,
        StPrA,
        StPrB,
        StPrC,
        StPrD,
        StPrE,
        StPrF,
        StDone
    } rc4_state_e;

endpackage

// File: rtl/rc4_ascii_check.sv
// Combinational plaintext filter: passes lower-case letters and space.
// Only instantiated when RC4_ASCII_CHECK_EN is defined.
module rc4_ascii_check
    import rc4_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_pass
);

    assign o_pass = ((i_byte >= ASCII_LO) && (i_byte <= ASCII_HI)) || (i_byte == ASCII_SP);

endmodule

// File: rtl/rc4_engine.sv
// RC4 engine: S-box fill, key scheduling and keystream XOR decrypt against external memories.
// Define RC4_ASCII_CHECK_EN to abort on the first non-letter/non-space plaintext byte.
module rc4_engine
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned MSG_LEN   = 32,
    parameter int unsigned MSG_AW    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wdata,
    output logic                   s_wren,
    input  logic [7:0]             s_q,
    output logic [MSG_AW-1:0]      m_addr,
    input  logic [7:0]             m_q,
    output logic [MSG_AW-1:0]      d_addr,
    output logic [7:0]             d_wdata,
    output logic                   d_wren,
    output logic                   busy,
    output logic                   done,
    output logic                   key_valid
);

    rc4_state_e             r_state, w_state_next;
    logic [7:0]             r_i, r_j, r_k, r_si, r_sj;
    logic [4:0]             r_kidx;
    logic [8*KEY_BYTES-1:0] r_key;
    logic [7:0]             w_key_byte, w_j_ksa, w_j_pr, w_dec;
    logic                   w_last_i, w_last_k, w_pass;

    always_comb begin
        w_key_byte = '0;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (r_kidx == 5'(n)) w_key_byte = r_key[(KEY_BYTES-1-n)*8 +: 8];
        end
    end

    assign w_j_ksa  = r_j + s_q + w_key_byte;
    assign w_j_pr   = r_j + s_q;
    assign w_dec    = s_q ^ m_q;
    assign w_last_i = (r_i == 8'(S_DEPTH - 1));
    assign w_last_k = (r_k == 8'(MSG_LEN - 1));

`ifdef RC4_ASCII_CHECK_EN
    logic r_key_valid;

    rc4_ascii_check u_ascii_check (
        .i_byte (w_dec),
        .o_pass (w_pass)
    );
    assign key_valid = done & r_key_valid;
`else
    assign w_pass    = 1'b1;
    assign key_valid = done;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle, StDone: if (start) w_state_next = StInit;
            StInit:         if (w_last_i) w_state_next = StKsaA;
            StKsaA:         w_state_next = StKsaB;
            StKsaB:         w_state_next = StKsaC;
            StKsaC:         w_state_next = StKsaD;
            StKsaD:         w_state_next = w_last_i ? StPrA : StKsaA;
            StPrA:          w_state_next = StPrB;
            StPrB:          w_state_next = StPrC;
            StPrC:          w_state_next = StPrD;
            StPrD:          w_state_next = StPrE;
            StPrE:          w_state_next = StPrF;
            StPrF:          w_state_next = (w_last_k || !w_pass) ? StDone : StPrA;
            default:        w_state_next = StIdle;
        endcase
    end

    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wren  = 1'b0;
        m_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;
        d_wren  = 1'b0;
        busy    = (r_state != StIdle) && (r_state != StDone);
        done    = (r_state == StDone);
        case (r_state)
            StInit: begin
                s_addr  = r_i;
                s_wdata = r_i;
                s_wren  = 1'b1;
            end
            StKsaA, StPrA: s_addr = r_i;
            StKsaB:        s_addr = w_j_ksa;
            StPrB:         s_addr = w_j_pr;
            StKsaC, StPrC: begin
                s_addr  = r_i;
                s_wdata = s_q;
                s_wren  = 1'b1;
            end
            StKsaD, StPrD: begin
                s_addr  = r_j;
                s_wdata = r_si;
                s_wren  = 1'b1;
            end
            StPrE:         s_addr = r_si + r_sj;
            StPrF: begin
                d_addr  = MSG_AW'(r_k);
                d_wdata = w_dec;
                d_wren  = 1'b1;
            end
            default: ;
        endcase
        // Message address is held for the whole byte so m_q is valid in PR_F.
        if (r_state inside {StPrA, StPrB, StPrC, StPrD, StPrE, StPrF}) m_addr = MSG_AW'(r_k);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_i    <= '0;
            r_j    <= '0;
            r_k    <= '0;
            r_si   <= '0;
            r_sj   <= '0;
            r_kidx <= '0;
            r_key  <= '0;
`ifdef RC4_ASCII_CHECK_EN
            r_key_valid <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_i    <= '0;
                        r_j    <= '0;
                        r_k    <= '0;
                        r_kidx <= '0;
                        r_key  <= key;
`ifdef RC4_ASCII_CHECK_EN
                        r_key_valid <= 1'b1;
`endif
                    end
                end
                StInit: r_i <= r_i + 8'd1;
                StKsaB: begin
                    r_si <= s_q;
                    r_j  <= w_j_ksa;
                end
                StKsaD: begin
                    r_kidx <= (r_kidx == 5'(KEY_BYTES - 1)) ? '0 : r_kidx + 5'd1;
                    if (w_last_i) begin
                        r_i <= 8'd1;
                        r_j <= '0;
                        r_k <= '0;
                    end else begin
                        r_i <= r_i + 8'd1;
                    end
                end
                StPrB: begin
                    r_si <= s_q;
                    r_j  <= w_j_pr;
                end
                StPrC: r_sj <= s_q;
                StPrF: begin
                    r_i <= r_i + 8'd1;
                    r_k <= r_k + 8'd1;
`ifdef RC4_ASCII_CHECK_EN
                    if (!w_pass) r_key_valid <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_engine.sv
// Self-checking bench for rc4_engine: memory models plus a software RC4 reference.
// Follows RC4_ASCII_CHECK_EN when computing expected results.
module tb_rc4_engine;

    localparam int KB = 3;
    localparam int ML = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset, start, d_clr;
    logic [8*KB-1:0] key;
    logic [7:0]    s_addr, s_wdata, s_q, m_q, d_wdata;
    logic          s_wren, d_wren, busy, done, key_valid;
    logic [AW-1:0] m_addr, d_addr;

    logic [7:0] s_mem [256];
    logic [7:0] rom   [256];
    logic [7:0] d_mem [256];
    logic [7:0] ks    [256];
    logic [7:0] exp_out [256];
    int s_wr_cnt = 0;
    int d_wr_cnt = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rc4_engine #(.KEY_BYTES(KB), .MSG_LEN(ML), .MSG_AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wren    (s_wren),
        .s_q       (s_q),
        .m_addr    (m_addr),
        .m_q       (m_q),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wren    (d_wren),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid)
    );

    // Synchronous memories: read data one cycle after the address, write at the edge.
    always @(posedge clk) begin
        if (s_wren) begin
            s_mem[s_addr] <= s_wdata;
            s_wr_cnt      <= s_wr_cnt + 1;
        end
        s_q <= s_mem[s_addr];
        m_q <= rom[m_addr];
        if (d_clr) begin
            for (int i = 0; i < 256; i++) d_mem[i] <= 8'h00;
        end else if (d_wren) begin
            d_mem[d_addr] <= d_wdata;
            d_wr_cnt      <= d_wr_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_text(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7a) || b == 8'h20;
    endfunction

    // Textbook RC4 on integer arrays.
    task automatic ref_keystream(input logic [8*KB-1:0] k);
        int s[256];
        int i, j, t, kb;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            kb = int'((k >> (8 * (KB - 1 - (n % KB)))) & 'hff);
            j = (j + s[n] + kb) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        for (int n = 0; n < ML; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks[n] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    task automatic run(input logic [8*KB-1:0] k, input int extra_start_at, input bit init_chk,
                       input string tag);
        int exp_nwr, n, base_s, base_d, bad;
        bit exp_valid, got;
        ref_keystream(k);
        exp_nwr   = ML;
        exp_valid = 1'b1;
        for (int i = 0; i < ML; i++) begin
            exp_out[i] = rom[i] ^ ks[i];
`ifdef RC4_ASCII_CHECK_EN
            if (exp_valid && !is_text(exp_out[i])) begin
                exp_nwr   = i + 1;
                exp_valid = 1'b0;
            end
`endif
        end
        @(negedge clk) d_clr = 1'b1;
        @(negedge clk) d_clr = 1'b0;
        key   = k;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        base_s = s_wr_cnt;
        base_d = d_wr_cnt;
        check_eq({tag, "_busy_after_start"}, 32'(busy), 1);
        check_eq({tag, "_done_after_start"}, 32'(done), 0);
        n   = 0;
        got = 1'b0;
        while (n < 4000 && !got) begin
            @(posedge clk);
            n++;
            #1 start = (n == extra_start_at);
            if (init_chk && n == 256) begin
                bad = 0;
                for (int i = 0; i < 256; i++) if (s_mem[i] !== 8'(i)) bad++;
                check_eq({tag, "_init_writes"}, 32'(s_wr_cnt - base_s), 256);
                check_eq({tag, "_init_identity_bad"}, 32'(bad), 0);
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        // n edges after the sampling edge; done is first high in cycle n+1 counted from start.
        check_eq({tag, "_latency"}, got ? 32'(n + 1) : 32'd0, 32'(1280 + 6 * exp_nwr + 1));
        check_eq({tag, "_busy_done"}, 32'(busy), 0);
        check_eq({tag, "_key_valid"}, 32'(key_valid), 32'(exp_valid));
        check_eq({tag, "_d_writes"}, 32'(d_wr_cnt - base_d), 32'(exp_nwr));
        for (int i = 0; i < exp_nwr; i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(d_mem[i]), 32'(exp_out[i]));
        end
        bad = 0;
        for (int i = exp_nwr; i < 256; i++) if (d_mem[i] !== 8'h00) bad++;
        check_eq({tag, "_untouched_bad"}, 32'(bad), 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_done_held"}, 32'(done), 1);
        check_eq({tag, "_idle_wren"}, 32'({s_wren, d_wren}), 0);
    endtask

    initial begin
        logic [7:0] pt [9];
        logic [7:0] ct [9];
        logic [8*KB-1:0] rk;
        int snap_s, snap_d;

        pt = '{8'h50, 8'h6c, 8'h61, 8'h69, 8'h6e, 8'h74, 8'h65, 8'h78, 8'h74};
        ct = '{8'hbb, 8'hf3, 8'h16, 8'he8, 8'hd9, 8'h40, 8'haf, 8'h0a, 8'hd3};
        reset = 1'b1;
        start = 1'b0;
        key   = '0;
        d_clr = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i * 37 + 5);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outputs", 32'({busy, done, key_valid, s_wren, d_wren}), 0);
        check_eq("rst_addrs", 32'({s_addr, m_addr, d_addr, s_wdata, d_wdata}), 0);
        reset = 1'b0;

        // Known vector: key "Key", ciphertext of "Plaintext", rest of ROM filler.
        for (int i = 0; i < 9; i++) rom[i] = ct[i];
        run(24'h4b6579, 0, 1'b1, "known");
        for (int i = 0; i < 9; i++) begin
            if (i < d_wr_cnt) check_eq($sformatf("plaintext%0d", i), 32'(d_mem[i]),
                `ifdef RC4_ASCII_CHECK_EN (i == 0) ? 32'(pt[i]) : 32'h0 `else 32'(pt[i]) `endif);
        end

        // Abort during key scheduling.
        @(negedge clk) key = 24'h123456;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (599) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_busy_done", 32'({busy, done}), 0);
        check_eq("abort_wren", 32'({s_wren, d_wren}), 0);
        reset  = 1'b0;
        snap_s = s_wr_cnt;
        snap_d = d_wr_cnt;
        repeat (10) @(posedge clk);
        #1;
        check_eq("abort_no_writes", 32'((s_wr_cnt - snap_s) + (d_wr_cnt - snap_d)), 0);
        run(24'h4b6579, 0, 1'b0, "after_abort");

        // Start pulse in the middle of PRGA must be ignored.
        run(24'h4b6579, 1300, 1'b0, "mid_start");

        // Random keys and messages, each started from DONE.
        for (int r = 0; r < 3; r++) begin
            rk = 24'($urandom);
            for (int i = 0; i < ML; i++) rom[i] = 8'($urandom);
            run(rk, 0, 1'b0, $sformatf("rand%0d", r));
        end

        // Random key with a text plaintext so every byte passes the checker.
        rk = 24'($urandom);
        ref_keystream(rk);
        for (int i = 0; i < ML; i++) begin
            rom[i] = ((i % 5) == 4) ? 8'h20 : 8'(8'h61 + $urandom_range(25));
            rom[i] = rom[i] ^ ks[i];
        end
        run(rk, 0, 1'b0, "text");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
